// File: rtl/bsg_noc_pkg.sv
// Shared NoC router types and helpers used by the wormhole arbiters and router assertions.
package bsg_noc_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } bsg_wormhole_arb_state_e;

  // Index of the set bit of a one-hot vector (lowest set bit if not one-hot).
  function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 31; i >= 0; i--) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

  function automatic int unsigned safe_clog2(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bsg_wormhole_rr_pick.sv
// Rotating-priority encoder: first set request strictly after last_i, wrapping around.
module bsg_wormhole_rr_pick
  import bsg_noc_pkg::*;
#(
  parameter int inputs_p    = 5,
  parameter int lg_inputs_p = 3
) (
  input  logic [inputs_p-1:0]    reqs_i,
  input  logic [lg_inputs_p-1:0] last_i,
  output logic [inputs_p-1:0]    grant_o,
  output logic [lg_inputs_p-1:0] idx_o,
  output logic                   v_o
);

  int   cand;
  logic found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = 0;
    // Offset inputs_p lands back on last_i, so a sole requester always wins.
    for (int off = 1; off <= inputs_p; off++) begin
      cand = (int'(last_i) + off) % inputs_p;
      if (!found && reqs_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = lg_inputs_p'(cand);
      end
    end
  end

  assign v_o = |reqs_i;

endmodule

// File: rtl/bsg_wormhole_output_arbiter.sv
// Per-output wormhole allocator: round-robin header arbitration, grant locked for whole packet.
module bsg_wormhole_output_arbiter
  import bsg_noc_pkg::*;
#(
  parameter int inputs_p    = 5,
  parameter int width_p     = 32,
  parameter int len_width_p = 4
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [inputs_p-1:0]             reqs_i,
  input  logic [inputs_p*len_width_p-1:0] len_i,
  input  logic [inputs_p*width_p-1:0]     data_i,
  output logic [inputs_p-1:0]             yumi_o,
  output logic                            v_o,
  output logic [width_p-1:0]              data_o,
  input  logic                            ready_and_i,
  output logic [inputs_p-1:0]             grant_o,
  output logic                            busy_o
);

  localparam int lg_inputs_lp = safe_clog2(inputs_p);

  bsg_wormhole_arb_state_e state_r, state_n;
  logic [inputs_p-1:0]     winner_r, winner_n;
  logic [lg_inputs_lp-1:0] last_r, last_n;
  logic [len_width_p-1:0]  count_r, count_n;

  logic [inputs_p-1:0]     pick_grant;
  logic [lg_inputs_lp-1:0] pick_idx;
  logic                    pick_v;
  logic [len_width_p-1:0]  head_len;
  logic                    xfer;

  bsg_wormhole_rr_pick #(
    .inputs_p   (inputs_p),
    .lg_inputs_p(lg_inputs_lp)
  ) u_pick (
    .reqs_i (reqs_i),
    .last_i (last_r),
    .grant_o(pick_grant),
    .idx_o  (pick_idx),
    .v_o    (pick_v)
  );

  always_comb begin
    head_len = '0;
    for (int i = 0; i < inputs_p; i++) begin
      if (pick_grant[i]) head_len |= len_i[i*len_width_p +: len_width_p];
    end
  end

  // Outputs are forced quiet while reset is held, even mid-packet.
  always_comb begin
    grant_o = '0;
    v_o     = 1'b0;
    if (!reset_i) begin
      if (state_r == IDLE) begin
        grant_o = pick_grant;
        v_o     = pick_v;
      end else begin
        grant_o = winner_r;
        v_o     = |(reqs_i & winner_r);
      end
    end
  end

  assign xfer   = v_o & ready_and_i;
  assign yumi_o = xfer ? grant_o : '0;
  assign busy_o = (state_r == BUSY) & ~reset_i;

  always_comb begin
    data_o = '0;
    for (int i = 0; i < inputs_p; i++) begin
      if (grant_o[i]) data_o |= data_i[i*width_p +: width_p];
    end
  end

  always_comb begin
    state_n  = state_r;
    winner_n = winner_r;
    last_n   = last_r;
    count_n  = count_r;
    unique case (state_r)
      IDLE: begin
        if (xfer) begin
          if (head_len == '0) begin
            last_n = pick_idx;
          end else begin
            state_n  = BUSY;
            winner_n = pick_grant;
            count_n  = head_len;
          end
        end
      end
      BUSY: begin
        if (xfer) begin
          count_n = count_r - len_width_p'(1);
          if (count_r == len_width_p'(1)) begin
            state_n  = IDLE;
            last_n   = lg_inputs_lp'(onehot_to_idx(32'(winner_r)));
            winner_n = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r  <= IDLE;
      winner_r <= '0;
      last_r   <= lg_inputs_lp'(inputs_p - 1);
      count_r  <= '0;
    end else begin
      state_r  <= state_n;
      winner_r <= winner_n;
      last_r   <= last_n;
      count_r  <= count_n;
    end
  end

endmodule

// File: tb/tb_bsg_wormhole_output_arbiter.sv
// Self-checking bench for bsg_wormhole_output_arbiter: vector table plus expectation queue.
module tb_bsg_wormhole_output_arbiter;

  localparam int N = 5;
  localparam int W = 32;
  localparam int LW = 4;

  logic            clk_i = 1'b0;
  logic            reset_i;
  logic [N-1:0]    reqs_i;
  logic [N*LW-1:0] len_i;
  logic [N*W-1:0]  data_i;
  logic [N-1:0]    yumi_o;
  logic            v_o;
  logic [W-1:0]    data_o;
  logic            ready_and_i;
  logic [N-1:0]    grant_o;
  logic            busy_o;

  bsg_wormhole_output_arbiter #(
    .inputs_p   (N),
    .width_p    (W),
    .len_width_p(LW)
  ) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .reqs_i     (reqs_i),
    .len_i      (len_i),
    .data_i     (data_i),
    .yumi_o     (yumi_o),
    .v_o        (v_o),
    .data_o     (data_o),
    .ready_and_i(ready_and_i),
    .grant_o    (grant_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string           nm;
    logic            rst;
    logic [N-1:0]    reqs;
    logic [N*LW-1:0] lens;
    logic            rdy;
    logic            ev;
    logic [N-1:0]    eg;
    logic [N-1:0]    ey;
    logic            eb;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cur_row = 0;

  function automatic logic [N*LW-1:0] ln(input int i, input int v);
    logic [N*LW-1:0] r;
    r = '0;
    r[i*LW +: LW] = LW'(v);
    return r;
  endfunction

  function automatic logic [W-1:0] flit(input int i);
    return 32'hD000_0000 + W'(i);
  endfunction

  function automatic void add(input string nm, input logic rst, input logic [N-1:0] reqs,
                              input logic [N*LW-1:0] lens, input logic rdy, input logic ev,
                              input logic [N-1:0] eg, input logic [N-1:0] ey, input logic eb);
    vec_t v;
    v.nm = nm; v.rst = rst; v.reqs = reqs; v.lens = lens; v.rdy = rdy;
    v.ev = ev; v.eg = eg; v.ey = ey; v.eb = eb;
    vecs.push_back(v);
  endfunction

  task automatic cmp(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h, expected %h", nm, cur_row, act, expv);
    end
  endtask

  task automatic step(input logic r, input logic [N-1:0] q, input logic [N*LW-1:0] l,
                      input logic rd);
    @(posedge clk_i);
    #1;
    reset_i     = r;
    reqs_i      = q;
    len_i       = l;
    ready_and_i = rd;
    @(negedge clk_i);
  endtask

  task automatic check_out();
    vec_t e;
    logic [W-1:0] ed;
    if (exp_q.size() == 0) begin
      cmp("sb_empty", 32'(exp_q.size()), 32'd1);
      return;
    end
    e = exp_q.pop_front();
    ed = '0;
    for (int i = 0; i < N; i++) if (e.eg[i]) ed |= flit(i);
    cmp({e.nm, "_v"}, 32'(v_o), 32'(e.ev));
    cmp({e.nm, "_grant"}, 32'(grant_o), 32'(e.eg));
    cmp({e.nm, "_yumi"}, 32'(yumi_o), 32'(e.ey));
    cmp({e.nm, "_busy"}, 32'(busy_o), 32'(e.eb));
    cmp({e.nm, "_data"}, data_o, ed);
    cmp({e.nm, "_yumi_1hot"}, 32'($onehot0(yumi_o)), 32'd1);
  endtask

  int n_xfer;

  initial begin
    reset_i = 1'b1; reqs_i = '0; len_i = '0; ready_and_i = 1'b0;
    for (int i = 0; i < N; i++) data_i[i*W +: W] = flit(i);

    // Alternation between inputs 0 and 2, single-flit packets.
    add("rst",   1, 5'b00101, '0, 1, 0, 5'b00000, 5'b00000, 0);
    add("alt1",  0, 5'b00101, '0, 1, 1, 5'b00001, 5'b00001, 0);
    add("alt2",  0, 5'b00101, '0, 1, 1, 5'b00100, 5'b00100, 0);
    add("alt3",  0, 5'b00101, '0, 1, 1, 5'b00001, 5'b00001, 0);
    add("alt4",  0, 5'b00101, '0, 1, 1, 5'b00100, 5'b00100, 0);
    // Input 1 len=3 packet locks out input 3 for 4 transfers.
    add("rstB",  1, 5'b01010, ln(1, 3), 1, 0, 5'b00000, 5'b00000, 0);
    add("pkt1",  0, 5'b01010, ln(1, 3), 1, 1, 5'b00010, 5'b00010, 0);
    add("pkt2",  0, 5'b01010, ln(1, 3), 1, 1, 5'b00010, 5'b00010, 1);
    add("pkt3",  0, 5'b01010, ln(1, 3), 1, 1, 5'b00010, 5'b00010, 1);
    add("pkt4",  0, 5'b01010, ln(1, 3), 1, 1, 5'b00010, 5'b00010, 1);
    add("pkt5",  0, 5'b01010, ln(1, 3), 1, 1, 5'b01000, 5'b01000, 0);
    // Bubble: input 1 drops request for 2 cycles while locked with count=2.
    add("rstC",  1, 5'b01010, ln(1, 3), 1, 0, 5'b00000, 5'b00000, 0);
    add("bub1",  0, 5'b01010, ln(1, 3), 1, 1, 5'b00010, 5'b00010, 0);
    add("bub2",  0, 5'b01010, ln(1, 3), 1, 1, 5'b00010, 5'b00010, 1);
    add("bub3",  0, 5'b01000, ln(1, 3), 1, 0, 5'b00010, 5'b00000, 1);
    add("bub4",  0, 5'b01000, ln(1, 3), 1, 0, 5'b00010, 5'b00000, 1);
    add("bub5",  0, 5'b01010, ln(1, 3), 1, 1, 5'b00010, 5'b00010, 1);
    add("bub6",  0, 5'b01010, ln(1, 3), 1, 1, 5'b00010, 5'b00010, 1);
    add("bub7",  0, 5'b01010, ln(1, 3), 1, 1, 5'b01000, 5'b01000, 0);
    // Downstream stall with inputs 0 and 4 pending.
    add("rstD",  1, 5'b10001, '0, 0, 0, 5'b00000, 5'b00000, 0);
    add("stl1",  0, 5'b10001, '0, 0, 1, 5'b00001, 5'b00000, 0);
    add("stl2",  0, 5'b10001, '0, 0, 1, 5'b00001, 5'b00000, 0);
    add("stl3",  0, 5'b10001, '0, 0, 1, 5'b00001, 5'b00000, 0);
    add("stl4",  0, 5'b10001, '0, 1, 1, 5'b00001, 5'b00001, 0);
    add("stl5",  0, 5'b10001, '0, 1, 1, 5'b10000, 5'b10000, 0);
    // Reset after 2 of 5 flits of an input 3 packet.
    add("rstF",  1, 5'b01000, ln(3, 4), 1, 0, 5'b00000, 5'b00000, 0);
    add("mid1",  0, 5'b01000, ln(3, 4), 1, 1, 5'b01000, 5'b01000, 0);
    add("mid2",  0, 5'b01000, ln(3, 4), 1, 1, 5'b01000, 5'b01000, 1);
    add("mrst",  1, 5'b01001, ln(3, 4), 1, 0, 5'b00000, 5'b00000, 0);
    add("post",  0, 5'b01001, ln(3, 4), 1, 1, 5'b00001, 5'b00001, 0);

    for (int k = 0; k < vecs.size(); k++) begin
      cur_row = k;
      exp_q.push_back(vecs[k]);
      step(vecs[k].rst, vecs[k].reqs, vecs[k].lens, vecs[k].rdy);
      check_out();
    end

    // Maximum length packet: 16 transfers, then back to IDLE.
    cur_row = -1;
    step(1, 5'b00100, ln(2, 15), 1);
    n_xfer = 0;
    for (int c = 0; c < 16; c++) begin
      step(0, 5'b00100, ln(2, 15), 1);
      if (yumi_o[2]) n_xfer++;
      cmp("len15_busy", 32'(busy_o), (c != 0) ? 32'd1 : 32'd0);
    end
    step(0, 5'b00000, '0, 1);
    cmp("len15_xfers", 32'(n_xfer), 32'd16);
    cmp("len15_idle_busy", 32'(busy_o), 32'd0);
    cmp("len15_idle_v", 32'(v_o), 32'd0);
    // Next header from a different input proves the lock was released.
    step(0, 5'b00001, '0, 1);
    cmp("len15_next_grant", 32'(grant_o), 32'b00001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
